// File: rtl/imem_loader.sv
// Loads little-endian N-bit words from a byte stream into imem from address 0, stalling the CPU.
// One write cycle follows every N/8 accepted bytes; byte_ready is high only while receiving.
module imem_loader #(
  parameter int N  = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW:0]   word_count,
  input  logic          abort,
  input  logic          byte_valid,
  input  logic [7:0]    byte_data,
  output logic          byte_ready,
  input  logic [AW-1:0] fetch_addr,
  output logic [AW-1:0] imem_addr,
  output logic          imem_we,
  output logic [N-1:0]  imem_wdata,
  output logic          cpu_stall,
  output logic          busy,
  output logic          done
);

  localparam int NB = N / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state;
  logic [AW:0]   remaining;
  logic [AW-1:0] wptr;
  logic [BW-1:0] byte_idx;
  logic [N-1:0]  asm_word;
  logic [N-1:0]  wdata;
  logic [N-1:0]  merged;
  logic          xfer;
  logic          last_byte;

  assign xfer      = byte_valid && byte_ready;
  assign last_byte = (byte_idx == BW'(NB - 1));

  always_comb begin
    merged = asm_word;
    merged[8*int'(byte_idx) +: 8] = byte_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      wptr      <= '0;
      byte_idx  <= '0;
      asm_word  <= '0;
      wdata     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            remaining <= word_count;
            wptr      <= '0;
            byte_idx  <= '0;
            asm_word  <= '0;
            state     <= (word_count == '0) ? S_DONE : S_RECV;
          end
        end
        S_RECV: begin
          if (abort) begin
            byte_idx <= '0;
            state    <= S_IDLE;
          end else if (xfer) begin
            asm_word <= merged;
            if (last_byte) begin
              byte_idx <= '0;
              wdata    <= merged;
              state    <= S_WRITE;
            end else begin
              byte_idx <= byte_idx + BW'(1);
            end
          end
        end
        S_WRITE: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            // Pointer wraps naturally; a full-depth load leaves it back at 0.
            wptr      <= wptr + AW'(1);
            remaining <= remaining - (AW+1)'(1);
            state     <= (remaining == (AW+1)'(1)) ? S_DONE : S_RECV;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = (state == S_RECV);
  assign imem_we    = (state == S_WRITE) && !abort;
  assign imem_addr  = (state == S_IDLE) ? fetch_addr : wptr;
  assign imem_wdata = wdata;
  assign cpu_stall  = (state != S_IDLE);
  assign busy       = (state == S_RECV) || (state == S_WRITE);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes, addresses and timing come from the load rules.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [6:0]  word_count;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [5:0]  fetch_addr;
  logic [5:0]  imem_addr;
  logic        imem_we;
  logic [31:0] imem_wdata;
  logic        cpu_stall;
  logic        busy;
  logic        done;

  imem_loader #(.N(32), .AW(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .word_count(word_count),
    .abort(abort), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .fetch_addr(fetch_addr), .imem_addr(imem_addr),
    .imem_we(imem_we), .imem_wdata(imem_wdata), .cpu_stall(cpu_stall),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int viol = 0;
  logic [31:0] words_tx [64];
  logic [5:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  int          done_q    [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (done) done_q.push_back(cyc);
    if (imem_we && byte_ready) viol++;
    if (busy && !cpu_stall) viol++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_q.delete();
    viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit r;
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        step();
      end
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    do begin
      r = byte_ready;
      step();
      n++;
    end while (!r && n < 30);
    if (!r) check("byte_accept_timeout", 0, 1);
    byte_valid = 1'b0;
  endtask

  task automatic begin_session(input int wc, output int c);
    start      = 1'b1;
    word_count = 7'(wc);
    c          = cyc;
    step();
    start      = 1'b0;
    word_count = 7'($urandom);
  endtask

  // Reference: word i lands at address i mod 64; at full byte rate word i is
  // written 5*i+5 cycles after the start cycle and done follows 5*wc+1 cycles after it.
  task automatic run_session(input int wc, input bit gaps, input bit poke_start);
    int c;
    int n;
    clear_log();
    begin_session(wc, c);
    for (int i = 0; i < wc; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (poke_start && i == 0 && b == 2) begin
          start = 1'b1;
          word_count = 7'd5;
          step();
          start = 1'b0;
        end
        send_byte(words_tx[i][8*b +: 8], gaps);
      end
    end
    n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    check("done_seen", done, 1);
    check("stall_in_done", cpu_stall, 1);
    check("busy_in_done", busy, 0);
    check("wptr_after_load", imem_addr, wc % 64);
    step();
    check("stall_after_done", cpu_stall, 0);
    check("done_single_cycle", done, 0);
    check("busy_after_done", busy, 0);
    if (wc > 0) check("wdata_hold", imem_wdata, words_tx[wc-1]);
    check("write_count", wr_addr_q.size(), wc);
    for (int i = 0; i < wc && i < wr_addr_q.size(); i++) begin
      check("wr_addr", wr_addr_q[i], i % 64);
      check("wr_data", wr_data_q[i], words_tx[i]);
      if (!gaps) check("wr_cycle", wr_cyc_q[i], c + 5*i + 5);
    end
    check("done_pulses", done_q.size(), 1);
    if (!gaps && done_q.size() == 1) check("done_cycle", done_q[0], c + 5*wc + 1);
    check("ready_or_stall_viol", viol, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_stall"}, cpu_stall, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, imem_addr, fetch_addr);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    reset_n    = 1'b0;
    start      = 1'b0;
    word_count = '0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    fetch_addr = 6'($urandom);
    repeat (2) step();
    check_reset_outputs("por");
    reset_n = 1'b1;
    step();

    // IDLE: address port follows the CPU with no added latency
    for (int k = 0; k < 4; k++) begin
      fetch_addr = 6'($urandom);
      #1;
      check("idle_fetch_addr", imem_addr, fetch_addr);
      check("idle_ready", byte_ready, 0);
      step();
    end

    // Reset in the middle of receiving
    begin_session(1, c);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    fetch_addr = 6'($urandom);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    reset_n = 1'b1;
    step();
    words_tx[0] = 32'hF800_0001;
    run_session(1, 1'b0, 1'b0);

    // Three words at full byte rate
    for (int i = 0; i < 3; i++) words_tx[i] = $urandom;
    run_session(3, 1'b0, 1'b0);

    // Throttled stream with a stray start pulse mid-session
    words_tx[0] = 32'h8B05_0083;
    words_tx[1] = 32'hCB05_0083;
    run_session(2, 1'b1, 1'b1);

    // Abort during the third byte of word 1
    clear_log();
    words_tx[0] = 32'hF800_8002;
    words_tx[1] = $urandom;
    begin_session(2, c);
    for (int b = 0; b < 4; b++) send_byte(words_tx[0][8*b +: 8], 1'b0);
    send_byte(words_tx[1][7:0], 1'b0);
    send_byte(words_tx[1][15:8], 1'b0);
    byte_valid = 1'b1;
    byte_data  = words_tx[1][23:16];
    abort      = 1'b1;
    step();
    abort      = 1'b0;
    byte_valid = 1'b0;
    fetch_addr = 6'h2A;
    #1;
    check("abort_fetch_addr", imem_addr, 6'h2A);
    check("abort_busy", busy, 0);
    check("abort_stall", cpu_stall, 0);
    repeat (8) step();
    check("abort_write_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() > 0) begin
      check("abort_wr_addr", wr_addr_q[0], 0);
      check("abort_wr_data", wr_data_q[0], 32'hF800_8002);
    end
    check("abort_no_done", done_q.size(), 0);

    // Abort landing on the write cycle suppresses the strobe
    clear_log();
    begin_session(3, c);
    for (int b = 0; b < 4; b++) send_byte(8'($urandom), 1'b0);
    abort = 1'b1;
    #1;
    check("abort_write_we", imem_we, 0);
    step();
    abort = 1'b0;
    check("abort_write_busy", busy, 0);
    repeat (4) step();
    check("abort_write_count2", wr_addr_q.size(), 0);
    check("abort_write_no_done", done_q.size(), 0);

    // Zero-length session
    run_session(0, 1'b0, 1'b0);

    // A few random throttled sessions
    for (int k = 0; k < 3; k++) begin
      int wc;
      wc = $urandom_range(1, 6);
      for (int i = 0; i < wc; i++) words_tx[i] = $urandom;
      run_session(wc, 1'b1, 1'b0);
    end

    // Full-depth load; pointer wraps back to 0
    for (int i = 0; i < 64; i++) words_tx[i] = $urandom;
    words_tx[63] = 32'hB400_001F;
    run_session(64, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
